// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares a single UART transmitter among four byte requesters. When no
//   requester owns the link, the next owner is picked round-robin. A
//   multi-byte frame locks the link to its owner until the owner sends its
//   last byte. If the transmitter never acknowledges a launch with tx_busy,
//   a watchdog times out, sets a sticky error and frees the link.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req       per-requester level request, held until acked
//   req_last  per-requester "this byte ends the frame"
//   req_data  requester i byte in bits [8i+7:8i]
//   req_ack   one-cycle pulse when requester i's byte launches
//   grant     one-hot current owner (zero when the link is free)
//   tx_data   byte to UART, stable from launch to next launch
//   tx_send   one-cycle launch strobe to UART
//   tx_busy   UART busy, rises the cycle after an accepted launch
//   err       sticky busy-timeout flag
//   idle      arbiter idle and no frame lock held
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16   // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  req_last,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ack,
    output logic [3:0]  grant,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        err,
    output logic        idle
);

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    // Counter value seen on the last tx_busy=0 cycle before timing out.
    localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    // Per-requester byte view of the flat data bus.
    logic [NUM_REQ-1:0][7:0] req_bytes;
    assign req_bytes = req_data;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic [7:0]         data_q, data_nxt;
    logic               locked, locked_nxt;
    logic               last_q, last_nxt;     // req_last of the byte in flight
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;       // round-robin search start
    logic               err_q, err_nxt;
    logic [7:0]         tmo_cnt, cnt_nxt;

    // ------------------------------------------------------------------
    // Round-robin pick: first requesting index at or after rr_ptr.
    // ------------------------------------------------------------------
    logic               rr_found;
    logic [IDX_W-1:0]   rr_win;
    logic [IDX_W-1:0]   rr_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_win   = rr_ptr;
        rr_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = rr_ptr + IDX_W'(i);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    // While locked only the owner is eligible; everyone else is ignored.
    logic             arb_go;
    logic [IDX_W-1:0] arb_win;

    always_comb begin
        arb_win = locked ? owner : rr_win;
        arb_go  = !tx_busy && (locked ? req[owner] : rr_found);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            owner   <= '0;
            grant_q <= '0;
            data_q  <= 8'h00;
            locked  <= 1'b0;
            last_q  <= 1'b0;
            rr_ptr  <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= 8'h00;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            grant_q <= grant_nxt;
            data_q  <= data_nxt;
            locked  <= locked_nxt;
            last_q  <= last_nxt;
            rr_ptr  <= rr_nxt;
            err_q   <= err_nxt;
            tmo_cnt <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        grant_nxt  = grant_q;
        data_nxt   = data_q;
        locked_nxt = locked;
        last_nxt   = last_q;
        rr_nxt     = rr_ptr;
        err_nxt    = err_q;
        cnt_nxt    = tmo_cnt;
        tx_send    = 1'b0;
        req_ack    = '0;

        case (state)
            S_IDLE: begin
                if (arb_go) begin
                    owner_nxt = arb_win;
                    grant_nxt = NUM_REQ'(1) << arb_win;
                    data_nxt  = req_bytes[arb_win];
                    last_nxt  = req_last[arb_win];
                    state_nxt = S_SEND;
                end
            end

            S_SEND: begin
                tx_send    = 1'b1;
                req_ack    = grant_q;
                // Lock follows the frame flag captured with the byte, not
                // whatever the requester drives now that it has been acked.
                locked_nxt = !last_q;
                cnt_nxt    = 8'h00;
                state_nxt  = S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    // Transmitter never took the byte: give up on the frame.
                    err_nxt    = 1'b1;
                    locked_nxt = 1'b0;
                    grant_nxt  = '0;
                    rr_nxt     = owner + IDX_W'(1);
                    state_nxt  = S_IDLE;
                end else if (tmo_cnt != 8'hFF) begin
                    cnt_nxt = tmo_cnt + 8'h01;
                end
            end

            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (locked && req[owner]) begin
                        // Back-to-back frame byte, skip the IDLE cycle.
                        data_nxt  = req_bytes[owner];
                        last_nxt  = req_last[owner];
                        state_nxt = S_SEND;
                    end else if (locked) begin
                        // Owner paused mid-frame: keep grant, wait in IDLE.
                        state_nxt = S_IDLE;
                    end else begin
                        grant_nxt = '0;
                        rr_nxt    = owner + IDX_W'(1);
                        state_nxt = S_IDLE;
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign grant   = grant_q;
    assign tx_data = data_q;
    assign err     = err_q;
    assign idle    = (state == S_IDLE) && !locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, round-robin rotation,
// locked frame, busy timeout and reset mid-frame.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        err;
    logic        idle;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_arbiter #(.BUSY_TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_last (req_last),
        .req_data (req_data),
        .req_ack  (req_ack),
        .grant    (grant),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .err      (err),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles starting the cycle after a launch.
    // Not tied to rst, so a transmission in flight survives an arbiter reset.
    logic busy_en = 1'b1;
    int   busy_cnt = 0;
    always @(posedge clk) begin
        if (busy_en && tx_send) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch log: byte, ack vector, and number of tx_busy=0 cycles right
    // before the launch (1 = straight from WAIT_DONE, 2 = via IDLE).
    logic [7:0] log_data[$];
    logic [3:0] log_ack[$];
    int         log_gap[$];
    int         quiet = 0;

    always @(negedge clk) begin
        if (tx_send) begin
            log_data.push_back(tx_data);
            log_ack.push_back(req_ack);
            log_gap.push_back(quiet);
            chk("send_while_busy", tx_busy, 1'b0);
        end
        if (req_ack != 4'b0000) chk("ack_outside_send", tx_send, 1'b1);
        quiet = tx_busy ? 0 : quiet + 1;
    end

    task automatic clear_log();
        log_data.delete();
        log_ack.delete();
        log_gap.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        req_last = '0;
        req_data = '0;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic wait_ack(input int i, input int bound);
        bit seen = 0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk);
            if (req_ack[i]) seen = 1;
        end
        chk("wait_ack", seen, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        for (int c = 0; c < bound && !idle; c++) @(negedge clk);
        chk("wait_idle", idle, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_ack[5];
        logic [7:0] exp_dat[5];
        int acks;
        int n;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_grant",   grant,   4'b0000);
        chk("rst_tx_send", tx_send, 1'b0);
        chk("rst_req_ack", req_ack, 4'b0000);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_err",     err,     1'b0);
        chk("rst_idle",    idle,    1'b1);

        // ---------------- single byte ----------------
        req = 4'b0100; req_last = 4'b0100; req_data[23:16] = 8'hA5;
        wait_ack(2, 20);
        chk("t1_tx_data", tx_data, 8'hA5);
        chk("t1_grant_send", grant, 4'b0100);
        req = '0;
        repeat (3) @(negedge clk);
        chk("t1_busy", tx_busy, 1'b1);
        chk("t1_grant_busy", grant, 4'b0100);
        wait_idle(50);
        chk("t1_grant_end", grant, 4'b0000);
        chk("t1_nsend", log_data.size(), 1);
        chk("t1_log_data", log_data[0], 8'hA5);
        chk("t1_log_ack", log_ack[0], 4'b0100);

        // ---------------- round robin ----------------
        do_reset();
        req = 4'b1111; req_last = 4'b1111; req_data = 32'h13121110;
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        acks = 0;
        for (int c = 0; c < 400 && acks < 5; c++) begin
            @(negedge clk);
            if (req_ack != 4'b0000) acks++;
        end
        req = '0;
        chk("t2_acks", acks, 5);
        wait_idle(50);
        chk("t2_nsend", log_data.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_ack%0d", k), log_ack[k], exp_ack[k]);
            chk($sformatf("t2_data%0d", k), log_data[k], exp_dat[k]);
            if (k > 0) chk($sformatf("t2_gap%0d", k), log_gap[k], 2);
        end

        // ---------------- locked frame ----------------
        do_reset();
        req = 4'b1010; req_last = 4'b1000;
        req_data[15:8] = 8'h01; req_data[31:24] = 8'h33;
        acks = 0;
        n = 0;
        for (int c = 0; c < 400 && n == 0; c++) begin
            @(negedge clk);
            if (req_ack[1]) begin
                acks++;
                if (acks == 1) req_data[15:8] = 8'h02;
                if (acks == 2) begin req_data[15:8] = 8'h03; req_last[1] = 1'b1; end
                if (acks == 3) req[1] = 1'b0;
            end
            if (req_ack[3]) begin req[3] = 1'b0; n = 1; end
        end
        wait_idle(50);
        chk("t3_nsend", log_data.size(), 4);
        chk("t3_d0", log_data[0], 8'h01);
        chk("t3_d1", log_data[1], 8'h02);
        chk("t3_d2", log_data[2], 8'h03);
        chk("t3_d3", log_data[3], 8'h33);
        chk("t3_a0", log_ack[0], 4'b0010);
        chk("t3_a1", log_ack[1], 4'b0010);
        chk("t3_a2", log_ack[2], 4'b0010);
        chk("t3_a3", log_ack[3], 4'b1000);
        chk("t3_gap1", log_gap[1], 1);
        chk("t3_gap2", log_gap[2], 1);
        chk("t3_gap3", log_gap[3], 2);

        // ---------------- busy timeout ----------------
        do_reset();
        busy_en = 1'b0;
        req = 4'b0001; req_last = 4'b1111; req_data[7:0] = 8'h5A;
        wait_ack(0, 20);
        req = '0;
        n = 0;
        for (int c = 0; c < 40 && !err; c++) begin
            @(negedge clk);
            n++;
        end
        // 16 WAIT_BUSY cycles follow the SEND cycle.
        chk("t4_tmo_cycles", n, 17);
        chk("t4_err", err, 1'b1);
        chk("t4_grant", grant, 4'b0000);
        chk("t4_idle", idle, 1'b1);
        busy_en = 1'b1;
        req = 4'b0010; req_data[15:8] = 8'h77;
        wait_ack(1, 20);
        req = '0;
        @(negedge clk);
        wait_idle(50);
        chk("t4_err_sticky", err, 1'b1);
        chk("t4_nsend", log_data.size(), 2);
        chk("t4_d1", log_data[1], 8'h77);
        chk("t4_a1", log_ack[1], 4'b0010);

        // ---------------- reset mid-frame ----------------
        do_reset();
        req = 4'b0010; req_last = 4'b0000; req_data[15:8] = 8'hC1;
        wait_ack(1, 20);
        repeat (2) @(negedge clk);    // now in WAIT_DONE of a locked frame
        rst = 1'b1;
        req = 4'b1111; req_last = 4'b1111; req_data = 32'h44332211;
        @(negedge clk);
        chk("t5_grant",   grant,   4'b0000);
        chk("t5_req_ack", req_ack, 4'b0000);
        chk("t5_tx_send", tx_send, 1'b0);
        chk("t5_tx_data", tx_data, 8'h00);
        chk("t5_err",     err,     1'b0);
        chk("t5_idle",    idle,    1'b1);
        rst = 1'b0;
        clear_log();
        n = 0;
        for (int c = 0; c < 50 && n == 0; c++) begin
            @(negedge clk);
            if (req_ack != 4'b0000) begin req = '0; n = 1; end
        end
        chk("t5_got_ack", n, 1);
        wait_idle(50);
        chk("t5_nsend", log_data.size(), 1);
        chk("t5_a0", log_ack[0], 4'b0001);
        chk("t5_d0", log_data[0], 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: BUSY_TIMEOUT, default 16, max cycles to wait for tx_busy to rise after tx_send.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req  in  4  per-requester byte request, level, held until acknowledged.
REQ-005 req_last  in  4  per-requester flag: current byte is the last byte of its frame.
REQ-006 req_data  in  32  byte for requester i at bits [8i+7:8i].
REQ-007 req_ack  out  4  one-cycle pulse: requester i's byte launched; requester may then change data.
REQ-008 grant  out  4  one-hot current owner, all-zero when no owner.
REQ-009 tx_data  out  8  byte to UART transmitter, stable from SEND until next SEND.
REQ-010 tx_send  out  1  one-cycle launch strobe to UART transmitter.
REQ-011 tx_busy  in  1  UART transmitter busy, rises the cycle after an accepted tx_send.
REQ-012 err  out  1  sticky timeout flag.
REQ-013 idle  out  1  high in IDLE with no lock held.

Function
REQ-014 States IDLE, SEND, WAIT_BUSY, WAIT_DONE; exactly one active.
REQ-015 IDLE: arbitrate only when tx_busy=0 and at least one eligible req; else stay.
REQ-016 Eligible set: all req bits when unlocked; only req[owner] when locked.
REQ-017 Unlocked choice is round-robin: search starts at (last owner + 1) mod 4; after reset the search starts at requester 0.
REQ-018 On arbitration at edge T: latch req_data of winner into tx_data, set grant, go to SEND.
REQ-019 SEND (one cycle): tx_send=1, req_ack[owner]=1. Lock set if req_last[owner]=0 as sampled at arbitration, cleared if 1. Next state WAIT_BUSY.
REQ-020 tx_send and req_ack are never high outside SEND; both exactly one cycle per byte.
REQ-021 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; the timeout counter is cleared on entry.
REQ-022 WAIT_BUSY timeout: BUSY_TIMEOUT cycles with tx_busy=0 -> err=1, lock cleared, grant=0, go IDLE.
REQ-023 WAIT_DONE: wait for tx_busy=0. If locked and req[owner]=1, latch new byte and go directly to SEND (no IDLE cycle); otherwise go IDLE.
REQ-024 Locked owner with req=0: stay in IDLE, grant held, other requesters ignored until owner sends its last byte.
REQ-025 Unlocked return to IDLE: grant=0, last-owner pointer updated to the finished owner.
REQ-026 req changes outside IDLE/WAIT_DONE-exit sampling points are ignored; req_data is sampled only at arbitration.
REQ-027 Simultaneous req on all four, unlocked: exactly one grant per arbitration, rotating 0,1,2,3,0...
REQ-028 err is cleared only by rst; operation continues normally after err.
REQ-029 Timeout counter is 8 bits, saturating; BUSY_TIMEOUT must be within 1..255.

Reset
REQ-030 On rst (sampled at clk edge): state IDLE, grant=0, req_ack=0, tx_send=0, tx_data=8'h00, err=0, lock cleared, round-robin pointer -> requester 0, idle=1.
REQ-031 rst mid-frame aborts without a further tx_send; the first post-reset grant waits for tx_busy=0 (REQ-015).

Verification
REQ-032 Single byte: req[2]=1, req_last[2]=1, data 8'hA5, tx_busy model rises 1 cycle after send and lasts 10 cycles -> one tx_send with tx_data=8'hA5, req_ack[2] pulse, grant=4'b0100 until busy falls, then idle=1.
REQ-033 Round-robin: req=4'b1111 held, all last=1 -> acks in order 0,1,2,3,0, one tx_send per busy window, no overlap.
REQ-034 Locked frame: req[1] frame 8'h01,8'h02,8'h03 (last on third), req[3] asserted throughout -> three consecutive bytes from requester 1, SEND follows WAIT_DONE with no IDLE cycle, then requester 3 granted.
REQ-035 Timeout: tx_busy tied 0, req[0]=1 -> after BUSY_TIMEOUT (16) cycles in WAIT_BUSY err=1, grant=0; next request still served once busy model is restored.
REQ-036 Reset mid-frame: rst during WAIT_DONE of a locked frame -> next cycle all outputs at reset values, no tx_send while tx_busy=1, requester 0 wins first post-reset arbitration under req=4'b1111.
